// File: rtl/picomips_pkg.sv
// Shared picoMIPS datapath definitions: default widths, the zero-register index and the write-back entry layout.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package picomips_pkg;

  localparam int N_DEFAULT    = 8;
  localparam int NREG_DEFAULT = 8;
  localparam int REG_ZERO     = 0;

  localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

  // Write-back entry at the default datapath size. Blocks that are
  // parameterised to other sizes declare a same-shaped local type.
  typedef struct packed {
    logic                  valid;
    logic [AW_DEFAULT-1:0] addr;
    logic [N_DEFAULT-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/regs_wb_rdport.sv
// Read-port mux: returns the zero register, the array entry, or (with REGS_WB_BYPASS_EN) the pending write-back data.
// Latency: 0 cycles, purely combinational from address, array contents and pending entry.
// Backpressure: none; a read is answered on every cycle.
module regs_rdport
  import picomips_pkg::*;
#(
  parameter int n    = N_DEFAULT,
  parameter int NREG = NREG_DEFAULT
) (
  input  logic [NREG*n-1:0]         regs_flat,
  input  logic [$clog2(NREG)-1:0]   raddr,
  input  logic                      pend_v,
  input  logic [$clog2(NREG)-1:0]   pend_addr,
  input  logic [n-1:0]              pend_data,
  output logic [n-1:0]              rdata
);

  localparam int AW = $clog2(NREG);

`ifndef REGS_WB_BYPASS_EN
  // Pending entry is only consulted when forwarding is built in.
  logic unused_bypass;
  assign unused_bypass = ^{pend_v, pend_addr, pend_data};
`endif

  // Zero register reads 0; otherwise array entry, overridden by a matching pending write when forwarding.
  always_comb begin
    rdata = '0;
    if (raddr != AW'(REG_ZERO)) begin
      rdata = regs_flat[int'(raddr)*n +: n];
`ifdef REGS_WB_BYPASS_EN
      if (pend_v && (pend_addr == raddr)) begin
        rdata = pend_data;
      end
`endif
    end
  end

endmodule

// File: rtl/regs_wb.sv
// picoMIPS 2-read/1-write register file with a one-deep write-back register; optional forwarding via REGS_WB_BYPASS_EN.
// Latency: write captured at edge k, committed at edge k+1; reads are combinational (0 cycles).
// Backpressure: none; a write is accepted every cycle, a commit and a new capture may share one edge.
module regs_wb
  import picomips_pkg::*;
#(
  parameter int n    = N_DEFAULT,
  parameter int NREG = NREG_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w,
  input  logic [$clog2(NREG)-1:0]   Waddr,
  input  logic [n-1:0]              wdata,
  input  logic [$clog2(NREG)-1:0]   Raddr1,
  input  logic [$clog2(NREG)-1:0]   Raddr2,
  output logic [n-1:0]              Rdata1,
  output logic [n-1:0]              Rdata2,
  output logic                      wb_pending
);

  localparam int AW = $clog2(NREG);

  // Write-back register states: IDLE holds nothing, PEND holds an uncommitted write.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // Same layout as wb_entry_t, sized to this instance's parameters.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [n-1:0]  data;
  } wb_t;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [AW-1:0] pend_addr;
  logic [n-1:0]  pend_data;
  wb_t           pend;
  logic          wr_vld;

  logic [n-1:0]       mem [NREG];
  logic [NREG*n-1:0]  regs_flat;

  // Writes aimed at the zero register are dropped before they reach the write-back register.
  assign wr_vld = w && (Waddr != AW'(REG_ZERO));

  // Next state: any valid write lands in PEND, otherwise the pending entry drains to IDLE.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = wr_vld ? ST_PEND : ST_IDLE;
      ST_PEND: state_nxt = wr_vld ? ST_PEND : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write-back register: capture the incoming write; reset discards whatever was pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      state <= state_nxt;
      if (wr_vld) begin
        pend_addr <= Waddr;
        pend_data <= wdata;
      end
    end
  end

  // Register array: commit the pending entry; it is read from the old register value, so a
  // capture on the same edge never overwrites what is being committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (state == ST_PEND) begin
      mem[pend_addr] <= pend_data;
    end
  end

  // Flatten the array so each read port can take it as a single vector.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
    assign regs_flat[gi*n +: n] = mem[gi];
  end

  assign pend.valid = (state == ST_PEND);
  assign pend.addr  = pend_addr;
  assign pend.data  = pend_data;

  assign wb_pending = pend.valid;

  regs_rdport #(.n(n), .NREG(NREG)) u_rd1 (
    .regs_flat (regs_flat),
    .raddr     (Raddr1),
    .pend_v    (pend.valid),
    .pend_addr (pend.addr),
    .pend_data (pend.data),
    .rdata     (Rdata1)
  );

  regs_rdport #(.n(n), .NREG(NREG)) u_rd2 (
    .regs_flat (regs_flat),
    .raddr     (Raddr2),
    .pend_v    (pend.valid),
    .pend_addr (pend.addr),
    .pend_data (pend.data),
    .rdata     (Rdata2)
  );

endmodule

// File: tb/tb_regs_wb.sv
// Directed bench for regs_wb: vector table of per-edge writes/reads plus reset sequences.
// Expectations follow the forwarding build selected by REGS_WB_BYPASS_EN.
module tb_regs_wb;

  localparam int N  = 8;
  localparam int NR = 8;
  localparam int AW = 3;
`ifdef REGS_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          w;
  logic [AW-1:0] Waddr;
  logic [N-1:0]  wdata;
  logic [AW-1:0] Raddr1;
  logic [AW-1:0] Raddr2;
  logic [N-1:0]  Rdata1;
  logic [N-1:0]  Rdata2;
  logic          wb_pending;

  int n_cmp;
  int n_bad;

  regs_wb #(.n(N), .NREG(NR)) dut (
    .clk        (clk),
    .reset      (reset),
    .w          (w),
    .Waddr      (Waddr),
    .wdata      (wdata),
    .Raddr1     (Raddr1),
    .Raddr2     (Raddr2),
    .Rdata1     (Rdata1),
    .Rdata2     (Rdata2),
    .wb_pending (wb_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          w;
    logic [AW-1:0] waddr;
    logic [N-1:0]  wdata;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [N-1:0]  exp1;
    logic [N-1:0]  exp2;
    logic          exp_pend;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic wv, input logic [AW-1:0] wa, input logic [N-1:0] wd,
                              input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [N-1:0] e1, input logic [N-1:0] e2, input logic ep);
    vec_t v;
    v.w = wv; v.waddr = wa; v.wdata = wd; v.ra1 = a1; v.ra2 = a2;
    v.exp1 = e1; v.exp2 = e2; v.exp_pend = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, take the edge, then sample 1 time unit later.
  task automatic drive(input logic rst, input logic wv, input logic [AW-1:0] wa, input logic [N-1:0] wd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    reset = rst; w = wv; Waddr = wa; wdata = wd; Raddr1 = a1; Raddr2 = a2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] sum;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; w = 1'b0; Waddr = '0; wdata = '0; Raddr1 = '0; Raddr2 = '0;
    #1;

    // Operands the ALU adds in the dual-read step.
    sum = 8'h7a + 8'h08;

    vecs[0]  = mk(1, 1, 8'h7a, 1, 0, BYP ? 8'h7a : 8'h00, 8'h00, 1);
    vecs[1]  = mk(0, 0, 8'h00, 1, 0, 8'h7a, 8'h00, 0);
    vecs[2]  = mk(1, 2, 8'h08, 2, 1, BYP ? 8'h08 : 8'h00, 8'h7a, 1);
    vecs[3]  = mk(1, 2, 8'h82, 2, 1, BYP ? 8'h82 : 8'h08, 8'h7a, 1);
    vecs[4]  = mk(0, 0, 8'h00, 2, 0, 8'h82, 8'h00, 0);
    vecs[5]  = mk(1, 0, 8'hff, 0, 0, 8'h00, 8'h00, 0);
    vecs[6]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    vecs[7]  = mk(1, 4, 8'h11, 4, 5, BYP ? 8'h11 : 8'h00, 8'h00, 1);
    vecs[8]  = mk(1, 5, 8'h22, 4, 5, 8'h11, BYP ? 8'h22 : 8'h00, 1);
    vecs[9]  = mk(0, 0, 8'h00, 4, 5, 8'h11, 8'h22, 0);
    vecs[10] = mk(1, 2, 8'h08, 1, 2, 8'h7a, BYP ? 8'h08 : 8'h82, 1);
    vecs[11] = mk(0, 0, 8'h00, 1, 2, 8'h7a, 8'h08, 0);
    vecs[12] = mk(1, 3, sum,   3, 2, BYP ? 8'h82 : 8'h00, 8'h08, 1);
    vecs[13] = mk(0, 0, 8'h00, 3, 0, 8'h82, 8'h00, 0);

    // Reset, then every register must read zero with nothing pending.
    drive(1, 1, 3, 8'hee, 0, 0);
    drive(0, 0, 0, 8'h00, 0, 0);
    for (int r = 0; r < NR; r++) begin
      Raddr1 = AW'(r);
      Raddr2 = AW'(NR - 1 - r);
      #1;
      check($sformatf("post_reset_r1_%0d", r), Rdata1, 8'h00);
      check($sformatf("post_reset_r2_%0d", r), Rdata2, 8'h00);
    end
    check("post_reset_pend", {7'd0, wb_pending}, 8'h00);

    // Table: one edge per record.
    for (int i = 0; i < 14; i++) begin
      drive(0, vecs[i].w, vecs[i].waddr, vecs[i].wdata, vecs[i].ra1, vecs[i].ra2);
      check($sformatf("vec%0d_r1", i), Rdata1, vecs[i].exp1);
      check($sformatf("vec%0d_r2", i), Rdata2, vecs[i].exp2);
      check($sformatf("vec%0d_pend", i), {7'd0, wb_pending}, {7'd0, vecs[i].exp_pend});
    end

    // Preload R3=55, then reset with a write request that must be ignored.
    drive(0, 1, 3, 8'h55, 3, 0);
    drive(0, 0, 0, 8'h00, 3, 0);
    check("preload_r3", Rdata1, 8'h55);
    drive(1, 1, 3, 8'haa, 3, 3);
    check("reset_r3_p1", Rdata1, 8'h00);
    check("reset_r3_p2", Rdata2, 8'h00);
    check("reset_pend", {7'd0, wb_pending}, 8'h00);
    drive(0, 0, 0, 8'h00, 3, 1);
    check("reset_r3_later", Rdata1, 8'h00);
    check("reset_r1_later", Rdata2, 8'h00);

    // Pending write to R6 discarded by reset on the following edge.
    drive(0, 1, 6, 8'h3c, 6, 0);
    check("r6_pend_before_reset", {7'd0, wb_pending}, 8'h01);
    drive(1, 0, 0, 8'h00, 6, 0);
    check("r6_after_reset", Rdata1, 8'h00);
    check("r6_pend_after_reset", {7'd0, wb_pending}, 8'h00);
    drive(0, 0, 0, 8'h00, 6, 6);
    check("r6_stays_zero_p1", Rdata1, 8'h00);
    check("r6_stays_zero_p2", Rdata2, 8'h00);

    // Same-address overwrite in three consecutive edges: last value wins.
    drive(0, 1, 7, 8'h01, 7, 0);
    drive(0, 1, 7, 8'h02, 7, 0);
    drive(0, 1, 7, 8'h03, 7, 0);
    check("r7_triple_mid", Rdata1, BYP ? 8'h03 : 8'h02);
    drive(0, 0, 0, 8'h00, 7, 0);
    check("r7_triple_final", Rdata1, 8'h03);
    check("r7_triple_pend", {7'd0, wb_pending}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regs_wb.md
# regs_wb

Register file and write-back stage of the picoMIPS datapath, directly upstream of the ALU. It supplies the two ALU operands (`a`, `b`) from a 2-read/1-write register array. It captures the ALU `result` through a one-deep write-back pipeline register, which is committed to the array on the following clock edge. Register 0 is hard-wired to zero. Optional forwarding hides the one-cycle commit delay from the read ports.

## Interface
- `n`, 8, data width; matches the ALU `n`.
- `NREG`, 8, number of registers; power of two, at least 2.
- `clk`  in  1  single system clock, rising-edge active.
- `reset`  in  1  synchronous, active-high reset.
- `w`  in  1  write request; `wdata` is captured into the write-back register on this edge.
- `Waddr`  in  $clog2(NREG)  destination register of the write request.
- `wdata`  in  n  write data, driven by ALU `result`.
- `Raddr1`  in  $clog2(NREG)  read port 1 address.
- `Raddr2`  in  $clog2(NREG)  read port 2 address.
- `Rdata1`  out  n  read port 1 data, drives ALU `a`.
- `Rdata2`  out  n  read port 2 data, drives ALU `b`.
- `wb_pending`  out  1  write-back register holds an uncommitted write.

## Operation
- **Storage:** `NREG` x `n` array; entry 0 is never written and always reads 0.
- **Write-back register:** `{pend_v, pend_addr, pend_data}`.
  - At an edge with `w`=1 and `Waddr`≠0: load `{1, Waddr, wdata}`.
  - At an edge with `w`=0, or with `Waddr`=0: `pend_v` is set to 0.
- **Commit:** at every edge where `pend_v`=1, `array[pend_addr] <= pend_data`.
- **Commit plus capture:** a commit and a new capture can occur at the same edge. The old entry is committed and the new one is captured, with no loss.
- **Back-to-back writes to the same address:** the first is committed at edge k+1 and the second at edge k+2. The final value is the second write.
- **Reads:** combinational. `Rdata` = 0 if the address is 0. Otherwise it is the array entry, or the forwarded pending data (see Configuration).
- **`wb_pending`:** equals `pend_v`.
- **Width rule:** `wdata` is stored unmodified at `n` bits. No extension or truncation is performed inside the block.
- **State machine:** two states per write-back register.
  - IDLE (`pend_v`=0) goes to PEND on a valid write.
  - PEND goes to PEND on a valid write, otherwise to IDLE.
  - PEND always commits on exit from the current cycle.

## Timing
- **Reset:** edge with `reset`=1 clears every array entry to 0 and sets `pend_v`=0. Any pending write is discarded, not committed. `w` is ignored during the reset edge.
- **Outputs after reset:** `Rdata1`=`Rdata2`=0 and `wb_pending`=0.
- **Write latency:** `w` sampled at edge k, array updated at edge k+1.
- **Visibility with forwarding:** new value visible on `Rdata` in the cycle after edge k.
- **Visibility without forwarding:** new value visible in the cycle after edge k+1.
- **Read latency:** 0 cycles (combinational from addresses and state).
- **Reset mid-operation:** a write captured at edge k followed by reset at edge k+1 is lost; the register reads 0.

## Configuration
- `REGS_WB_BYPASS_EN` defined: if `pend_v`=1 and `Raddr`=`pend_addr`≠0, `Rdata` returns `pend_data`. This applies independently to each port.
- `REGS_WB_BYPASS_EN` undefined: `Rdata` always returns the array contents. The controller must insert one bubble between a write and a dependent read.

## Structure
- **Package `picomips_pkg`:**
  - default width `N_DEFAULT`=8 and `NREG_DEFAULT`=8;
  - `REG_ZERO`=0;
  - typedef `wb_entry_t` (valid, addr, data).
- ALU function codes stay in the existing shared ALU codes include; this block does not use them.
- **Sub-module `regs_rdport`:** address-to-data mux containing the zero-register check and the optional bypass compare. It is instantiated twice, once per read port.

## Test plan
- **Reset:** preload R3=8'h55, assert `reset` for one edge → `Rdata1`(R3)=0, `wb_pending`=0.
- **Write then read:** `w`=1, `Waddr`=1, `wdata`=8'h7a at edge 1, then `Raddr1`=1.
  - Bypass on: 8'h7a in the cycle after edge 1.
  - Bypass off: old value 0 after edge 1, 8'h7a after edge 2.
- **Zero register:** `w`=1, `Waddr`=0, `wdata`=8'hff → `wb_pending`=0, and `Rdata1`(R0)=0 on all following cycles.
- **Back-to-back writes:**
  - Same address: R2←8'h08 at edge 1, R2←8'h82 at edge 2 → after edge 3, R2=8'h82.
  - Different addresses: R4←8'h11, R5←8'h22 on consecutive edges → both committed, none dropped.
- **Dual read feeding the ALU:** R1=8'h7a, R2=8'h08, `Raddr1`=1, `Raddr2`=2, ALU set to ADD → `result`=8'h82. Write it to R3 → R3=8'h82.
- **Reset with a pending write:** R6←8'h3c at edge 1, `reset` at edge 2 → R6=0, `wb_pending`=0.
